sdr_wb_arbiter: RTL
===================

Name: sdr_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that lets NUM_M application masters share the single Wishbone slave port of the SDRAM controller top level.
- Sits between the requesters and the controller's wishbone interface, in the wb_clk_i domain.
- Holds off every grant until the controller reports sdr_init_done.
- Runs a per-strobe ack watchdog so that a hung transfer cannot lock the SDRAM port.

Parameters:
- NUM_M, 4, number of masters (2..8).
- AW, 26, application address width.
- DW, 32, application data width.
- SW, DW/8, byte-select width.
- TIMEOUT, 255, max wb_clk_i cycles from s_stb_o assertion to s_ack_i before the transfer is aborted; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  system Wishbone clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- sdr_init_done  in  1  SDRAM init complete (already synchronised to wb_clk_i).
- m_cyc_i  in  NUM_M  per-master cycle.
- m_stb_i  in  NUM_M  per-master strobe.
- m_we_i  in  NUM_M  per-master write enable.
- m_addr_i  in  NUM_M*AW  packed addresses; master i at [i*AW +: AW].
- m_dat_i  in  NUM_M*DW  packed write data.
- m_sel_i  in  NUM_M*SW  packed byte selects.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o  out  NUM_M  per-master ack.
- m_err_o  out  NUM_M  per-master watchdog error pulse.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to controller.
- s_addr_o  out  AW  to controller.
- s_dat_o  out  DW  to controller.
- s_sel_o  out  SW  to controller.
- s_dat_i  in  DW  read data from controller.
- s_ack_i  in  1  ack from controller.
- grant_o  out  NUM_M  one-hot current owner; all-zero when none.
- busy_o  out  1  high when the state is OWN or ABORT.

Behaviour:
- Reset, applied asynchronously:
  - state=WAIT_INIT, grant_o=0, last=NUM_M-1, wdog=0, m_err_o=0.
  - All s_* outputs are 0; m_ack_o=0; m_dat_o=0.
- States:
  - WAIT_INIT -> IDLE when sdr_init_done=1. No grants in WAIT_INIT.
  - IDLE: if any m_cyc_i is high, pick the first requester searching from last+1 upward, modulo NUM_M. Register grant_o, set last to the winner, go to OWN. Grant is visible on the next cycle, giving 1-cycle arbitration latency.
  - OWN: s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_dat_o/s_sel_o are a combinational mux of the granted master's inputs, gated by grant.
    - m_ack_o[i] = s_ack_i & grant_o[i], combinational.
    - m_dat_o = s_dat_i when any grant is active, else 0.
    - Owner keeps the grant across multiple strobes for as long as its m_cyc_i stays high.
    - When the owner drops m_cyc_i: clear grant_o, go to IDLE. Exactly one dead cycle follows before the next grant, and s_cyc_o is 0 during that cycle.
  - ABORT: entered from OWN when wdog reaches TIMEOUT (TIMEOUT!=0).
    - m_err_o[owner]=1 for exactly one cycle; m_ack_o is not asserted for that strobe.
    - All s_* outputs are forced to 0 while in ABORT, even though grant_o stays set.
    - Leave when the owner drops m_cyc_i: clear grant, go to IDLE.
- Watchdog:
  - wdog counts wb_clk_i cycles while in OWN with s_stb_o=1 and s_ack_i=0.
  - Cleared on s_ack_i, on s_stb_o=0, and on leaving OWN.
  - Saturates at TIMEOUT.
- Boundary conditions:
  - A master that raises m_stb_i without m_cyc_i is ignored.
  - A late s_ack_i that arrives in ABORT or IDLE is dropped: no m_ack_o.
  - sdr_init_done falling while in IDLE/OWN is ignored (init is one-shot).
  - A new request in the same cycle the owner drops cyc is arbitrated in the following IDLE cycle.
  - Round-robin pointer wraps from NUM_M-1 to 0.
  - The lowest-index requester wins only relative to the last+1 search start.

Test Plan:
- Init hold: m_cyc_i=4'b0001 with sdr_init_done=0 for 50 cycles -> grant_o=0, s_cyc_o=0; raise init_done -> grant_o=4'b0001 after 2 cycles.
- Single write: master 2 writes addr 0x100, data 0xDEADBEEF, sel 4'hF; controller acks 5 cycles later -> s_addr_o=0x100, s_dat_o=0xDEADBEEF, m_ack_o=4'b0100 for exactly 1 cycle.
- Round-robin: all four masters hold cyc and each does one strobe then drops cyc, starting from last=3 -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Burst hold: master 1 does 8 back-to-back reads with cyc held, while master 3 requests -> all 8 complete before grant_o=4'b1000, and m_dat_o matches s_dat_i on each ack.
- Watchdog: TIMEOUT=16, controller never acks master 0 -> m_err_o[0]=1 on cycle 16 after stb rises, s_cyc_o drops to 0; an s_ack_i injected one cycle later produces no m_ack_o.
- Reset mid-op: assert wb_rst_i during an OWN burst of master 2 -> grant_o, s_cyc_o, and m_ack_o go to 0 immediately; after release, state is WAIT_INIT and the first grant with all masters requesting goes to master 0.

Source files
------------

// File: rtl/sdr_wb_arbiter.sv
// rtl/sdr_wb_arbiter.sv - round-robin Wishbone arbiter in front of the SDRAM controller port
module sdr_wb_arbiter #(
   parameter int NUM_M   = 4,
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int SW      = DW / 8,
   parameter int TIMEOUT = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                sdr_init_done,
   input  logic [NUM_M-1:0]    m_cyc_i,
   input  logic [NUM_M-1:0]    m_stb_i,
   input  logic [NUM_M-1:0]    m_we_i,
   input  logic [NUM_M*AW-1:0] m_addr_i,
   input  logic [NUM_M*DW-1:0] m_dat_i,
   input  logic [NUM_M*SW-1:0] m_sel_i,
   output logic [DW-1:0]       m_dat_o,
   output logic [NUM_M-1:0]    m_ack_o,
   output logic [NUM_M-1:0]    m_err_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [AW-1:0]       s_addr_o,
   output logic [DW-1:0]       s_dat_o,
   output logic [SW-1:0]       s_sel_o,
   input  logic [DW-1:0]       s_dat_i,
   input  logic                s_ack_i,
   output logic [NUM_M-1:0]    grant_o,
   output logic                busy_o
);

   localparam int LW = $clog2(NUM_M);
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

   typedef enum logic [1:0] {S_WAIT_INIT, S_IDLE, S_OWN, S_ABORT} state_t;

   state_t            state, state_nxt;
   logic [NUM_M-1:0]  grant_q;
   logic [LW-1:0]     last_q;
   logic [WW-1:0]     wdog_q;
   logic [WW-1:0]     wdog_inc;
   logic [NUM_M-1:0]  err_q;
   logic [NUM_M-1:0]  pick;
   logic [LW-1:0]     pick_idx;
   logic              pick_vld;
   logic              own_cyc, own_stb, own_we;
   logic [AW-1:0]     own_addr;
   logic [DW-1:0]     own_dat;
   logic [SW-1:0]     own_sel;
   logic              is_own;
   logic              wd_count;
   logic              wd_expire;

   assign is_own    = (state == S_OWN);
   assign wd_count  = s_stb_o & ~s_ack_i;
   assign wdog_inc  = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
   assign wd_expire = (TIMEOUT != 0) && wd_count && (wdog_inc == WD_MAX);

   // Round-robin search: first requester above the last owner, then wrap to the bottom
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      pick     = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (!pick_vld && m_cyc_i[i] && (i > int'(last_q))) begin
            pick_vld = 1'b1;
            pick_idx = LW'(i);
            pick[i]  = 1'b1;
         end
      end
      for (int i = 0; i < NUM_M; i++) begin
         if (!pick_vld && m_cyc_i[i] && (i <= int'(last_q))) begin
            pick_vld = 1'b1;
            pick_idx = LW'(i);
            pick[i]  = 1'b1;
         end
      end
   end

   // Owner's request signals selected by the one-hot grant
   always_comb begin
      own_cyc  = 1'b0;
      own_stb  = 1'b0;
      own_we   = 1'b0;
      own_addr = '0;
      own_dat  = '0;
      own_sel  = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (grant_q[i]) begin
            own_cyc  = m_cyc_i[i];
            own_stb  = m_stb_i[i];
            own_we   = m_we_i[i];
            own_addr = m_addr_i[i*AW +: AW];
            own_dat  = m_dat_i[i*DW +: DW];
            own_sel  = m_sel_i[i*SW +: SW];
         end
      end
   end

   // State register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= S_WAIT_INIT;
      else          state <= state_nxt;
   end

   // Next-state: init is one-shot, owner keeps the port while its cyc stays high
   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT_INIT: if (sdr_init_done) state_nxt = S_IDLE;
         S_IDLE:      if (pick_vld)      state_nxt = S_OWN;
         S_OWN: begin
            if (!own_cyc)       state_nxt = S_IDLE;
            else if (wd_expire) state_nxt = S_ABORT;
         end
         S_ABORT:     if (!own_cyc)      state_nxt = S_IDLE;
         default:     state_nxt = S_WAIT_INIT;
      endcase
   end

   // Outputs: slave side only driven in OWN; ABORT keeps the grant but silences the port
   always_comb begin
      s_cyc_o  = is_own & own_cyc;
      s_stb_o  = is_own & own_cyc & own_stb;
      s_we_o   = is_own & own_we;
      s_addr_o = is_own ? own_addr : '0;
      s_dat_o  = is_own ? own_dat  : '0;
      s_sel_o  = is_own ? own_sel  : '0;
      m_ack_o  = is_own ? (grant_q & {NUM_M{s_ack_i}}) : '0;
      m_dat_o  = (|grant_q) ? s_dat_i : '0;
      m_err_o  = err_q;
      grant_o  = grant_q;
      busy_o   = (state == S_OWN) || (state == S_ABORT);
   end

   // Grant, round-robin pointer, ack watchdog and error pulse
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         grant_q <= '0;
         last_q  <= LW'(NUM_M - 1);
         wdog_q  <= '0;
         err_q   <= '0;
      end else begin
         if (state == S_IDLE && pick_vld) begin
            grant_q <= pick;
            last_q  <= pick_idx;
         end else if (state_nxt == S_IDLE) begin
            grant_q <= '0;
         end
         if (is_own && wd_count) wdog_q <= wdog_inc;
         else                    wdog_q <= '0;
         if (is_own && state_nxt == S_ABORT) err_q <= grant_q;
         else                                err_q <= '0;
      end
   end

endmodule
